// File: rtl/dot_pkg.sv
// Shared types and defaults for the dot-product operand loader and its accelerator.
package dot_pkg;

  localparam int N_ELEM      = 8;
  localparam int DATA_W      = 32;
  localparam int RES_W       = 2 * DATA_W;
  localparam int TIMEOUT_CYC = 1024;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [RES_W-1:0]  res_t;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    CAPT,
    RESULT
  } state_t;

  // Index width that stays legal for a single-element bank.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dot_operand_loader_operand_bank.sv
// Operand register file, one element written per cycle at idx; latency 1 cycle.
// Never back-pressures; contents persist until overwritten or reset.
module operand_bank
  import dot_pkg::*;
#(
  parameter int N_ELEM = dot_pkg::N_ELEM,
  parameter int DATA_W = dot_pkg::DATA_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               we,
  input  logic [idx_w(N_ELEM)-1:0]           idx,
  input  logic [DATA_W-1:0]                  wdata,
  output logic [N_ELEM-1:0][DATA_W-1:0]      bank
);

  logic [N_ELEM-1:0][DATA_W-1:0] bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else if (we) begin
      bank_q[idx] <= wdata;
    end
  end

  assign bank = bank_q;

endmodule

// File: rtl/dot_operand_loader.sv
// Loads a then b operand banks from a word stream, runs the accelerator, returns its result (DOT_OPERAND_LOADER_TIMEOUT_EN adds a WAIT timeout).
// Latency 2*N_ELEM + 1 + acc latency + 2 cycles; in_ready only in LOAD states, result held until res_ready.
module dot_operand_loader
  import dot_pkg::*;
#(
  parameter int N_ELEM      = dot_pkg::N_ELEM,
  parameter int DATA_W      = dot_pkg::DATA_W,
  parameter int RES_W       = dot_pkg::RES_W,
  parameter int TIMEOUT_CYC = dot_pkg::TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          soft_clr,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [N_ELEM-1:0][DATA_W-1:0] acc_a,
  output logic [N_ELEM-1:0][DATA_W-1:0] acc_b,
  output logic                          acc_start,
  input  logic                          acc_done,
  input  logic [RES_W-1:0]              acc_result,
  output logic                          res_valid,
  output logic [RES_W-1:0]              res_data,
  input  logic                          res_ready,
  output logic                          busy,
  output logic                          err
);

  localparam int IDX_W = idx_w(N_ELEM);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             xfer, last, we_a, we_b, timeout;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign xfer     = in_valid && in_ready && !soft_clr;
  assign last     = (idx_q == IDX_W'(N_ELEM - 1));
  assign we_a     = xfer && (state_q == LOAD_A);
  assign we_b     = xfer && (state_q == LOAD_B);

`ifdef DOT_OPERAND_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero outside WAIT, so it restarts on every entry to WAIT.
  assign cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == WAIT) && !acc_done && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (soft_clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  operand_bank #(.N_ELEM(N_ELEM), .DATA_W(DATA_W)) u_bank_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_a),
    .idx   (idx_q),
    .wdata (in_data),
    .bank  (acc_a)
  );

  operand_bank #(.N_ELEM(N_ELEM), .DATA_W(DATA_W)) u_bank_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_b),
    .idx   (idx_q),
    .wdata (in_data),
    .bank  (acc_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      LOAD_A, LOAD_B: begin
        if (xfer) begin
          if (last) begin
            idx_d   = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (acc_done) begin
          state_d = CAPT;
        end else if (timeout) begin
          state_d = RESULT;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      // Sampled a cycle after done so a result registered alongside done is caught.
      CAPT: begin
        res_d   = acc_result;
        state_d = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
      default: state_d = LOAD_A;
    endcase
    if (soft_clr) begin
      state_d = LOAD_A;
      idx_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign acc_start = (state_q == START);
  assign res_valid = (state_q == RESULT);
  assign res_data  = res_q;
  assign busy      = !((state_q == LOAD_A) && (idx_q == '0));
  assign err       = err_q;

endmodule

// File: tb/tb_dot_operand_loader.sv
// Scoreboarded bench for dot_operand_loader with a behavioural accelerator (result registered alongside done).
// Define DOT_OPERAND_LOADER_TIMEOUT_EN to exercise the WAIT timeout path.
module tb_dot_operand_loader;
  import dot_pkg::*;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int RW  = 64;
  localparam int TMO = 16;
  localparam int LAT = 4;

  typedef logic [DW-1:0] vec_t [N];

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  soft_clr = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DW-1:0]         in_data = '0;
  logic                  in_ready;
  logic [N-1:0][DW-1:0]  acc_a, acc_b;
  logic                  acc_start;
  logic                  acc_done;
  logic [RW-1:0]         acc_result;
  logic                  res_valid;
  logic [RW-1:0]         res_data;
  logic                  res_ready = 1'b0;
  logic                  busy, err;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  logic [RW-1:0] sb[$];

  always #5 clk = ~clk;

  dot_operand_loader #(.N_ELEM(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_a(acc_a), .acc_b(acc_b), .acc_start(acc_start),
    .acc_done(acc_done), .acc_result(acc_result),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  // Accelerator model: fixed latency, optional hang, plus an injectable stray done.
  logic [N-1:0][DW-1:0] cap_a, cap_b;
  int            acc_cnt;
  logic          model_done;
  logic [RW-1:0] model_res;
  logic          force_done = 1'b0;
  logic          hang = 1'b0;

  assign acc_done   = model_done | force_done;
  assign acc_result = model_res;

  function automatic logic [RW-1:0] dot(input logic [N-1:0][DW-1:0] a, input logic [N-1:0][DW-1:0] b);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 0; model_done <= 1'b0; model_res <= '0; cap_a <= '0; cap_b <= '0;
    end else begin
      model_done <= 1'b0;
      if (acc_start && !hang) begin
        acc_cnt <= LAT; cap_a <= acc_a; cap_b <= acc_b;
      end else if (acc_cnt == 1) begin
        acc_cnt <= 0; model_done <= 1'b1; model_res <= dot(cap_a, cap_b);
      end else if (acc_cnt > 1) begin
        acc_cnt <= acc_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (rst_n && acc_start) n_start++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  // Streams a then b words; returns at the negedge after the last transfer.
  task automatic stream(input vec_t va, input vec_t vb, input bit toggle, input int nw, output bit ok);
    int sent = 0;
    int cyc = 0;
    bit ph = 1'b1;
    logic fire;
    while (sent < nw && cyc < 400) begin
      in_data  = (sent < N) ? va[sent] : vb[sent-N];
      in_valid = toggle ? ph : 1'b1;
      ph       = !ph;
      fire     = in_valid && in_ready;
      step();
      if (fire) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    ok = (sent == nw);
  endtask

  task automatic wait_result(output bit ok);
    int cyc = 0;
    while (!res_valid && cyc < 200) begin step(); cyc++; end
    ok = res_valid;
  endtask

  vec_t a1 = '{1, 2, 3, 4, 5, 6, 7, 8};
  vec_t b1 = '{10, 10, 10, 10, 1, 1, 1, 1};
  vec_t a2 = '{10, -5, 100, -1, 0, 20, -2, 1};
  vec_t b2 = '{2, 10, -1, 20, 50, -5, 4, -8};
  vec_t a3 = '{15, 25, 35, 45, 55, 65, 75, 85};
  vec_t z8 = '{0, 0, 0, 0, 0, 0, 0, 0};

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({acc_start, res_valid, busy, err} !== 4'b0000 || res_data !== '0 || acc_a !== '0 || acc_b !== '0) begin
      n_fail++; $display("FAIL reset_outputs: start/valid/busy/err=%b res=%0h required all zero", {acc_start, res_valid, busy, err}, res_data);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    bit ok; int s0; logic [RW-1:0] exp;
    s0 = n_start;
    stream(a1, b1, 1'b0, 2*N, ok);
    n_chk++;
    if (ok !== 1'b1 || acc_start !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: done=%b acc_start=%b required 1/1", ok, acc_start);
    end
    sb.push_back(RW'(126));
    step();
    n_chk++;
    if (acc_start !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_start_pulse: acc_start=%b in_ready=%b required 0/0", acc_start, in_ready);
    end
    wait_result(ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_chk++;
    if (ok !== 1'b1 || res_data !== exp) begin
      n_fail++; $display("FAIL basic_result: valid=%b res=%0d required 1/%0d", ok, $signed(res_data), $signed(exp));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (res_valid !== 1'b1 || res_data !== exp) begin
        n_fail++; $display("FAIL basic_hold: valid=%b res=%0d required 1/%0d", res_valid, $signed(res_data), $signed(exp));
      end
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_drain: valid=%b busy=%b in_ready=%b required 0/0/1", res_valid, busy, in_ready);
    end
    n_chk++;
    if (n_start - s0 !== 1) begin
      n_fail++; $display("FAIL basic_start_count: starts=%0d required 1", n_start - s0);
    end
  endtask

  task automatic test_toggle();
    bit ok; logic [RW-1:0] exp;
    stream(a2, b2, 1'b1, 2*N, ok);
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL toggle_transfers: complete=%b required 1", ok);
    end
    sb.push_back(RW'(-266));
    wait_result(ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_chk++;
    if (ok !== 1'b1 || res_data !== exp) begin
      n_fail++; $display("FAIL toggle_result: valid=%b res=%0h required 1/%0h", ok, res_data, exp);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL toggle_drain: valid=%b busy=%b required 0/0", res_valid, busy);
    end
  endtask

  task automatic test_hold();
    bit ok; logic [RW-1:0] exp;
    stream(a3, z8, 1'b0, 2*N, ok);
    sb.push_back(RW'(0));
    wait_result(ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (res_valid !== 1'b1 || res_data !== exp || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: valid=%b res=%0h in_ready=%b required 1/%0h/0", i, res_valid, res_data, in_ready, exp);
      end
      step();
    end
    in_valid = 1'b0;
    res_ready = 1'b1; step(); res_ready = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || acc_a[0] !== 32'd15) begin
      n_fail++; $display("FAIL hold_drain: valid=%b busy=%b a0=%0d required 0/0/15", res_valid, busy, acc_a[0]);
    end
  endtask

  task automatic test_soft_clr();
    bit ok; int s0; logic [RW-1:0] exp;
    s0 = n_start;
    stream(a1, b1, 1'b0, 5, ok);
    soft_clr = 1'b1; step(); soft_clr = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || acc_a[4] !== 32'd5) begin
      n_fail++; $display("FAIL softclr_state: busy=%b in_ready=%b a4=%0d required 0/1/5", busy, in_ready, acc_a[4]);
    end
    stream(a1, b1, 1'b0, 2*N, ok);
    sb.push_back(RW'(126));
    wait_result(ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_chk++;
    if (ok !== 1'b1 || res_data !== exp) begin
      n_fail++; $display("FAIL softclr_result: valid=%b res=%0d required 1/%0d", ok, $signed(res_data), $signed(exp));
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    n_chk++;
    if (n_start - s0 !== 1) begin
      n_fail++; $display("FAIL softclr_start_count: starts=%0d required 1", n_start - s0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int s0; logic [RW-1:0] exp;
    s0 = n_start;
    stream(a1, b1, 1'b0, 2*N, ok);
    step();
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || acc_start !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_wait: busy=%b in_ready=%b start=%b required 1/0/0", busy, in_ready, acc_start);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({acc_start, res_valid, busy, err} !== 4'b0000 || res_data !== '0 || acc_a !== '0 || acc_b !== '0) begin
      n_fail++; $display("FAIL rstmid_async: start/valid/busy/err=%b res=%0h required all zero", {acc_start, res_valid, busy, err}, res_data);
    end
    @(negedge clk); rst_n = 1'b1;
    force_done = 1'b1; step(); force_done = 1'b0; step();
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || n_start - s0 !== 1) begin
      n_fail++; $display("FAIL rstmid_late_done: valid=%b busy=%b in_ready=%b starts=%0d required 0/0/1/1", res_valid, busy, in_ready, n_start - s0);
    end
    stream(a1, b1, 1'b0, 2*N, ok);
    sb.push_back(RW'(126));
    wait_result(ok);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_chk++;
    if (ok !== 1'b1 || res_data !== exp) begin
      n_fail++; $display("FAIL rstmid_rerun: valid=%b res=%0d required 1/%0d", ok, $signed(res_data), $signed(exp));
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    hang = 1'b1;
    stream(a2, b2, 1'b0, 2*N, ok);
`ifdef DOT_OPERAND_LOADER_TIMEOUT_EN
    begin
      logic [RW-1:0] exp;
      sb.push_back(RW'(0));
      for (int i = 0; i < TMO; i++) step();
      n_chk++;
      if (res_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_early: valid=%b err=%b required 0/0", res_valid, err);
      end
      step();
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_chk++;
      if (err !== 1'b1 || res_valid !== 1'b1 || res_data !== exp) begin
        n_fail++; $display("FAIL timeout_fire: err=%b valid=%b res=%0h required 1/1/%0h", err, res_valid, res_data, exp);
      end
      res_ready = 1'b1; step(); res_ready = 1'b0;
      n_chk++;
      if (err !== 1'b1 || res_valid !== 1'b0) begin
        n_fail++; $display("FAIL timeout_sticky: err=%b valid=%b required 1/0", err, res_valid);
      end
      soft_clr = 1'b1; step(); soft_clr = 1'b0;
      n_chk++;
      if (err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_clear: err=%b required 0", err);
      end
    end
`else
    for (int i = 0; i < 40; i++) step();
    n_chk++;
    if (res_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL hang_wait: valid=%b err=%b busy=%b required 0/0/1", res_valid, err, busy);
    end
    soft_clr = 1'b1; step(); soft_clr = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL hang_abort: busy=%b in_ready=%b err=%b required 0/1/0", busy, in_ready, err);
    end
`endif
    hang = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_hold();
    test_soft_clr();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
